// File: rtl/ahb_manager_pipelined_pkg.sv
// ahb_manager_pipelined_pkg: shared AHB-Lite encodings and command type for the pipelined manager
package ahb_pkg;
  typedef enum logic [1:0] {TRANS_IDLE = 2'b00, TRANS_BUSY = 2'b01, TRANS_NONSEQ = 2'b10, TRANS_SEQ = 2'b11} transfer_type_e;
  typedef enum logic [2:0] {SIZE_BYTE = 3'b000, SIZE_HALF = 3'b001, SIZE_WORD = 3'b010, SIZE_DWORD = 3'b011} transfer_size_e;
  typedef enum logic [2:0] {BURST_SINGLE = 3'b000, BURST_INCR = 3'b001, BURST_WRAP4 = 3'b010, BURST_INCR4 = 3'b011} burst_e;
  typedef enum logic {DIR_READ = 1'b0, DIR_WRITE = 1'b1} transfer_direction_e;
  typedef enum logic {RESP_OKAY = 1'b0, RESP_ERROR = 1'b1} resp_e;
  localparam int CMD_ADDR_WIDTH = 32;
  localparam int CMD_DATA_WIDTH = 32;
  typedef struct packed {
    logic                      write;
    logic [2:0]                size;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_DATA_WIDTH-1:0] wdata;
  } cmd_t;
  localparam logic [2:0] HBURST_SINGLE = BURST_SINGLE;
endpackage

// File: rtl/ahb_manager_pipelined_if.sv
// ahb_manager_pipelined_if: command/response stream plus AHB-Lite manager bus
interface ahb_manager_pipelined_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [2:0]            cmd_size;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;
  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb_manager_pipelined_resp_tracker.sv
// ahb_manager_resp_tracker: data-phase register, response generation and two-cycle ERROR handling
module ahb_manager_resp_tracker #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  a_valid,
  input  logic                  a_write,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  d_valid,
  output logic                  err_state,
  output logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);
  logic d_write;
  // advance the address phase into the data phase; an address phase cancelled by ERROR never enters
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      HWDATA  <= '0;
    end else if (HREADY) begin
      d_valid <= a_valid && !err_state;
      if (!err_state) begin
        d_write <= a_write;
        HWDATA  <= a_wdata;
      end
    end
  end
  // first ERROR cycle (HREADY low) parks the manager; the completing cycle releases it
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) err_state <= 1'b0;
    else if (HREADY) err_state <= 1'b0;
    else if (d_valid && HRESP) err_state <= 1'b1;
  end
  // one response pulse per completed data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= HREADY && d_valid;
      if (HREADY && d_valid) begin
        rsp_rdata <= d_write ? '0 : HRDATA;
        rsp_error <= HRESP;
      end
    end
  end
endmodule

// File: rtl/ahb_manager_pipelined.sv
// ahb_manager_pipelined: valid/ready commands to pipelined AHB-Lite single transfers (lane replication via AHB_MANAGER_LANE_REPLICATE_EN)
module ahb_manager_pipelined
  import ahb_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] MAX_SIZE   = 3'b010
) (
  input logic                    HCLK,
  input logic                    HRESET,
  ahb_manager_pipelined_if.master bus
);
  logic                  a_valid, a_write, d_valid, err_state, cmd_fire;
  logic [2:0]            a_size, cmd_size_c;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata, cmd_wdata_l;
  assign bus.cmd_ready = !err_state && (!a_valid || bus.HREADY);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign cmd_size_c    = bus.cmd_size > MAX_SIZE ? MAX_SIZE : bus.cmd_size;
`ifdef AHB_MANAGER_LANE_REPLICATE_EN
  assign cmd_wdata_l = cmd_size_c == SIZE_BYTE ? {(DATA_WIDTH/8){bus.cmd_wdata[7:0]}} :
                       cmd_size_c == SIZE_HALF ? {(DATA_WIDTH/16){bus.cmd_wdata[15:0]}} : bus.cmd_wdata;
`else
  assign cmd_wdata_l = bus.cmd_wdata;
`endif
  // address-phase register: load on accept, retire when the bus moves it on, hold otherwise
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_size  <= '0;
      a_addr  <= '0;
      a_wdata <= '0;
    end else if (cmd_fire) begin
      a_valid <= 1'b1;
      a_write <= bus.cmd_write;
      a_size  <= cmd_size_c;
      a_addr  <= bus.cmd_addr;
      a_wdata <= cmd_wdata_l;
    end else if (bus.HREADY && !err_state) begin
      a_valid <= 1'b0;
    end
  end
  assign bus.HADDR  = a_addr;
  assign bus.HSIZE  = a_size;
  assign bus.HWRITE = a_write;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HTRANS = a_valid && !err_state ? TRANS_NONSEQ : TRANS_IDLE;
  assign bus.busy   = a_valid || d_valid || err_state;
  ahb_manager_resp_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_trk (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HREADY    (bus.HREADY),
    .HRESP     (bus.HRESP),
    .HRDATA    (bus.HRDATA),
    .a_valid   (a_valid),
    .a_write   (a_write),
    .a_wdata   (a_wdata),
    .d_valid   (d_valid),
    .err_state (err_state),
    .HWDATA    (bus.HWDATA),
    .rsp_valid (bus.rsp_valid),
    .rsp_rdata (bus.rsp_rdata),
    .rsp_error (bus.rsp_error)
  );
endmodule

// File: tb/tb_ahb_manager_pipelined.sv
// tb_ahb_manager_pipelined: directed scenarios plus randomized traffic against an ordered slave/response model
module tb_ahb_manager_pipelined;
  import ahb_pkg::*;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int checks = 0;
  int failures = 0;
  ahb_manager_pipelined_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  ahb_manager_pipelined #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_SIZE(3'b010)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] lanes(input logic [2:0] sz, input logic [31:0] wd);
`ifdef AHB_MANAGER_LANE_REPLICATE_EN
    return sz == 3'd0 ? {4{wd[7:0]}} : sz == 3'd1 ? {2{wd[15:0]}} : wd;
`else
    return wd;
`endif
  endfunction

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick;
    @(negedge HCLK);
  endtask

  task automatic drive(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_size  = sz;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
  endtask

  task automatic test_reset;
    tick;
    tick;
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HBURST} !== '0) begin
      failures++;
      $display("FAIL reset_addr_ctrl: got trans=%b addr=%h size=%b write=%b burst=%b want all zero", bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HBURST);
    end
    checks++;
    if ({bus.HWDATA, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.busy} !== '0) begin
      failures++;
      $display("FAIL reset_data_rsp: got hwdata=%h rsp_valid=%b rdata=%h err=%b busy=%b want all zero", bus.HWDATA, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.busy);
    end
    HRESET = 1'b0;
    tick;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.HTRANS} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_release: got ready=%b busy=%b trans=%b want 1 0 00", bus.cmd_ready, bus.busy, bus.HTRANS);
    end
  endtask

  task automatic test_zero_wait_writes;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = 32'hffffffff;
    drive(1'b1, 3'd0, 32'h1000, 32'h12);
    tick;
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE} !== {2'b10, 32'h1000, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL zw_addr0: got trans=%b addr=%h size=%b write=%b want 10 1000 000 1", bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE);
    end
    drive(1'b1, 3'd1, 32'h1004, 32'h3456);
    tick;
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE} !== {2'b10, 32'h1004, 3'd1, 1'b1}) begin
      failures++;
      $display("FAIL zw_addr1: got trans=%b addr=%h size=%b write=%b want 10 1004 001 1", bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE);
    end
    checks++;
    if (bus.HWDATA !== lanes(3'd0, 32'h12)) begin
      failures++;
      $display("FAIL zw_wdata0: got %h want %h", bus.HWDATA, lanes(3'd0, 32'h12));
    end
    drive(1'b1, 3'd2, 32'h1008, 32'h789abcde);
    tick;
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HSIZE} !== {2'b10, 32'h1008, 3'd2}) begin
      failures++;
      $display("FAIL zw_addr2: got trans=%b addr=%h size=%b want 10 1008 010", bus.HTRANS, bus.HADDR, bus.HSIZE);
    end
    checks++;
    if (bus.HWDATA !== lanes(3'd1, 32'h3456)) begin
      failures++;
      $display("FAIL zw_wdata1: got %h want %h", bus.HWDATA, lanes(3'd1, 32'h3456));
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL zw_rsp0: got valid=%b err=%b rdata=%h want 1 0 0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata);
    end
    bus.cmd_valid = 1'b0;
    tick;
    checks++;
    if ({bus.HTRANS, bus.HWDATA, bus.rsp_valid, bus.rsp_rdata} !== {2'b00, 32'h789abcde, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL zw_cycle4: got trans=%b hwdata=%h rsp_valid=%b rdata=%h want 00 789abcde 1 0", bus.HTRANS, bus.HWDATA, bus.rsp_valid, bus.rsp_rdata);
    end
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL zw_rsp2: got valid=%b err=%b rdata=%h want 1 0 0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata);
    end
    tick;
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      failures++;
      $display("FAIL zw_idle: got rsp_valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_wait_read;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    drive(1'b0, 3'd2, 32'h2000, 32'h0);
    tick;
    drive(1'b0, 3'd2, 32'h2004, 32'h0);
    tick;
    bus.cmd_valid = 1'b0;
    bus.HREADY = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick;
      checks++;
      if ({bus.HTRANS, bus.HADDR, bus.rsp_valid, bus.busy} !== {2'b10, 32'h2004, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL wait_hold%0d: got trans=%b addr=%h rsp_valid=%b busy=%b want 10 2004 0 1", w, bus.HTRANS, bus.HADDR, bus.rsp_valid, bus.busy);
      end
    end
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hdeadbeef;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== {2'b10, 32'hdeadbeef}) begin
      failures++;
      $display("FAIL wait_rsp: got valid=%b err=%b rdata=%h want 1 0 deadbeef", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata);
    end
    bus.HRDATA = 32'h11112222;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h11112222}) begin
      failures++;
      $display("FAIL wait_rsp2: got valid=%b rdata=%h want 1 11112222", bus.rsp_valid, bus.rsp_rdata);
    end
    tick;
  endtask

  task automatic test_error;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    drive(1'b1, 3'd2, 32'h3000, 32'hcafef00d);
    tick;
    drive(1'b0, 3'd2, 32'h3004, 32'h0);
    tick;
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA} !== {2'b10, 32'h3004, 1'b0, 32'hcafef00d}) begin
      failures++;
      $display("FAIL err_setup: got trans=%b addr=%h write=%b hwdata=%h want 10 3004 0 cafef00d", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA);
    end
    bus.cmd_valid = 1'b0;
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    tick;
    checks++;
    if ({bus.HTRANS, bus.busy, bus.rsp_valid, bus.cmd_ready} !== 5'b00100) begin
      failures++;
      $display("FAIL err_idle: got trans=%b busy=%b rsp_valid=%b ready=%b want 00 1 0 0", bus.HTRANS, bus.busy, bus.rsp_valid, bus.cmd_ready);
    end
    bus.HREADY = 1'b1;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.HTRANS, bus.HADDR} !== {2'b11, 2'b10, 32'h3004}) begin
      failures++;
      $display("FAIL err_rsp_reissue: got valid=%b err=%b trans=%b addr=%h want 1 1 10 3004", bus.rsp_valid, bus.rsp_error, bus.HTRANS, bus.HADDR);
    end
    bus.HRESP = 1'b0;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.HTRANS} !== 3'b000) begin
      failures++;
      $display("FAIL err_gap: got rsp_valid=%b trans=%b want 0 00", bus.rsp_valid, bus.HTRANS);
    end
    bus.HRDATA = 32'h55aa55aa;
    tick;
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_rdata} !== {2'b10, 32'h55aa55aa}) begin
      failures++;
      $display("FAIL err_retry_rsp: got valid=%b err=%b rdata=%h want 1 0 55aa55aa", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata);
    end
    tick;
  endtask

  task automatic test_clamp;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    drive(1'b1, 3'b011, 32'h4000, 32'h01234567);
    tick;
    checks++;
    if (bus.HSIZE !== 3'b010) begin
      failures++;
      $display("FAIL clamp_011: got %b want 010", bus.HSIZE);
    end
    drive(1'b0, 3'b111, 32'h4002, 32'h0);
    tick;
    checks++;
    if ({bus.HSIZE, bus.HADDR} !== {3'b010, 32'h4002}) begin
      failures++;
      $display("FAIL clamp_111: got size=%b addr=%h want 010 4002", bus.HSIZE, bus.HADDR);
    end
    bus.cmd_valid = 1'b0;
    repeat (3) tick;
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    drive(1'b1, 3'd2, 32'h5000, 32'h13572468);
    tick;
    drive(1'b0, 3'd2, 32'h5004, 32'h0);
    tick;
    bus.cmd_valid = 1'b0;
    bus.HREADY = 1'b0;
    tick;
    #1 HRESET = 1'b1;
    #1;
    checks++;
    if ({bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HWDATA, bus.rsp_valid, bus.rsp_rdata, bus.rsp_error, bus.busy} !== '0) begin
      failures++;
      $display("FAIL rstmid_values: got trans=%b addr=%h size=%b write=%b hwdata=%h busy=%b want reset values", bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWRITE, bus.HWDATA, bus.busy);
    end
    tick;
    HRESET = 1'b0;
    bus.HREADY = 1'b1;
    repeat (4) begin
      tick;
      if (bus.rsp_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL rstmid_no_rsp: got %0d rsp pulses want 0", pulses);
    end
  endtask

  task automatic test_lane;
    logic [31:0] exp;
`ifdef AHB_MANAGER_LANE_REPLICATE_EN
    exp = 32'ha5a5a5a5;
`else
    exp = 32'h000000a5;
`endif
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    drive(1'b1, 3'd0, 32'h1001, 32'ha5);
    tick;
    checks++;
    if (bus.HADDR !== 32'h1001) begin
      failures++;
      $display("FAIL lane_addr: got %h want 00001001", bus.HADDR);
    end
    bus.cmd_valid = 1'b0;
    tick;
    checks++;
    if (bus.HWDATA !== exp) begin
      failures++;
      $display("FAIL lane_hwdata: got %h want %h", bus.HWDATA, exp);
    end
    repeat (2) tick;
  endtask

  task automatic test_random;
    cmd_t iq[$];
    logic [32:0] rq[$];
    cmd_t cur, dp, e;
    logic have, dp_valid, taken, popped;
    have = 1'b0;
    dp_valid = 1'b0;
    cur = '0;
    dp = '0;
    bus.HRESP = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (bus.rsp_valid) begin
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rnd_rsp_extra: got unexpected rsp rdata=%h want no response", bus.rsp_rdata);
        end else begin
          if ({bus.rsp_error, bus.rsp_rdata} !== rq[0]) begin
            failures++;
            $display("FAIL rnd_rsp: got err=%b rdata=%h want err=%b rdata=%h", bus.rsp_error, bus.rsp_rdata, rq[0][32], rq[0][31:0]);
          end
          void'(rq.pop_front());
        end
      end
      if (c >= 340 && rq.size() == 0 && iq.size() == 0 && !dp_valid && !bus.busy) break;
      bus.HREADY = $urandom_range(0, 3) != 0;
      bus.HRDATA = (bus.HREADY && dp_valid && !dp.write) ? slave_data(dp.addr) : $urandom;
      if (bus.HREADY && dp_valid && dp.write) begin
        checks++;
        if (bus.HWDATA !== lanes(dp.size, dp.wdata)) begin
          failures++;
          $display("FAIL rnd_hwdata: got %h want %h addr=%h", bus.HWDATA, lanes(dp.size, dp.wdata), dp.addr);
        end
      end
      if (c < 340 && !have) begin
        cur.write = 1'($urandom);
        cur.size  = 3'($urandom);
        cur.addr  = $urandom;
        cur.wdata = $urandom;
        have = 1'b1;
      end
      bus.cmd_valid = c < 340 && have && $urandom_range(0, 2) != 0;
      bus.cmd_write = cur.write;
      bus.cmd_size  = cur.size;
      bus.cmd_addr  = cur.addr;
      bus.cmd_wdata = cur.wdata;
      #1;
      checks++;
      if (bus.HTRANS !== 2'b00 && bus.HTRANS !== 2'b10) begin
        failures++;
        $display("FAIL rnd_htrans: got %b want 00 or 10", bus.HTRANS);
      end
      taken = bus.HREADY && bus.HTRANS === 2'b10;
      popped = 1'b0;
      if (taken) begin
        checks++;
        if (iq.size() == 0) begin
          failures++;
          $display("FAIL rnd_issue_extra: got NONSEQ addr=%h want no transfer", bus.HADDR);
        end else begin
          if ({bus.HADDR, bus.HSIZE, bus.HWRITE} !== {iq[0].addr, iq[0].size, iq[0].write}) begin
            failures++;
            $display("FAIL rnd_issue: got addr=%h size=%b write=%b want addr=%h size=%b write=%b", bus.HADDR, bus.HSIZE, bus.HWRITE, iq[0].addr, iq[0].size, iq[0].write);
          end
          dp = iq.pop_front();
          popped = 1'b1;
          rq.push_back({1'b0, dp.write ? 32'h0 : slave_data(dp.addr)});
        end
      end
      if (bus.HREADY) dp_valid = popped;
      if (bus.cmd_valid && bus.cmd_ready) begin
        e = cur;
        if (e.size > 3'd2) e.size = 3'd2;
        iq.push_back(e);
        have = 1'b0;
      end
      tick;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (rq.size() != 0 || iq.size() != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rnd_drain: got pending_rsp=%0d pending_issue=%0d busy=%b want 0 0 0", rq.size(), iq.size(), bus.busy);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_size  = 3'd0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = 32'h0;
    test_reset;
    test_zero_wait_writes;
    test_wait_read;
    test_error;
    test_clamp;
    test_reset_mid;
    test_lane;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_manager_pipelined.md
Name: ahb_manager_pipelined

Overview:
- Parametrised AHB-Lite manager that turns a valid/ready command stream into AHB single transfers (NONSEQ, HBURST=SINGLE).
- Reads and writes are supported. The address phase of command N+1 overlaps the data phase of command N.
- Each completed transfer returns one response: read data plus an error flag.
- Sits between test/sequencer logic and the DPI-connected AHB subordinate in simulation; fully synthesizable.

Parameters:
- ADDR_WIDTH, 32, HADDR/cmd_addr width.
- DATA_WIDTH, 32, HWDATA/HRDATA width; legal values 32 or 64.
- MAX_SIZE, 3'b010, largest accepted HSIZE; larger cmd_size is clamped to MAX_SIZE.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
- cmd_write  in  1  1=write, 0=read
- cmd_size  in  3  HSIZE encoding
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data, lane-aligned
- rsp_valid  out  1  one-cycle pulse per completed transfer; no backpressure
- rsp_rdata  out  DATA_WIDTH  HRDATA captured (reads); 0 for writes
- rsp_error  out  1  HRESP was ERROR for this transfer
- busy  out  1  address or data phase outstanding
- HADDR  out  ADDR_WIDTH
- HBURST  out  3  constant 3'b000
- HSIZE  out  3
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only
- HWRITE  out  1
- HWDATA  out  DATA_WIDTH
- HRDATA  in  DATA_WIDTH
- HREADY  in  1
- HRESP  in  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0. Reset mid-transfer discards all outstanding state and produces no response.
- Two pipeline registers:
  - A: address phase. Drives HADDR/HSIZE/HWRITE/HTRANS=NONSEQ while valid, else HTRANS=IDLE.
  - D: data phase. Holds write flag; drives HWDATA.
- cmd_ready = !err_state && (!A.valid || HREADY). This is combinational on HREADY.
- Posedge with HREADY=1:
  - A moves into D; HWDATA <= A.wdata.
  - An accepted command loads A; otherwise A goes invalid.
  - If D was valid, its transfer completes: rsp_valid=1 next cycle, rsp_rdata=HRDATA (0 if write), rsp_error=HRESP.
- HREADY=0: A and D hold; HADDR and controls stable.
- Back-to-back throughput is 1 transfer/cycle with zero wait states. Latency from cmd accept to rsp_valid is 2 cycles at zero wait.
- Error handling:
  - HRESP=1 with HREADY=0 (first error cycle): enter err_state and drive HTRANS=IDLE next cycle. A is retained, not lost.
  - Second error cycle (HREADY=1): rsp_error=1. err_state clears, and retained A is re-issued as NONSEQ on the following cycle.
- Size clamp: cmd_size > MAX_SIZE is issued as MAX_SIZE. cmd_addr is not realigned; misaligned addresses pass through unchanged.
- busy = A.valid || D.valid || err_state.
- A cmd arriving in the same cycle that D completes is accepted (simultaneous accept and completion).

Optional Feature:
- Macro: AHB_MANAGER_LANE_REPLICATE_EN.
- Defined: write data for sub-word HSIZE is replicated across all byte lanes. Byte: cmd_wdata[7:0] on every byte; halfword: [15:0] on every halfword. Subordinates may then ignore lane selection.
- Undefined: HWDATA = cmd_wdata verbatim.

Decomposition:
- Package ahb_pkg holds:
  - enums transfer_type_e, transfer_size_e, burst_e, transfer_direction_e, resp_e;
  - a cmd_t struct {write, size, addr, wdata};
  - HBURST_SINGLE constant.
- Sub-module ahb_manager_resp_tracker covers the D register, response generation and err_state.

Test Plan:
- Zero-wait writes: byte 0x12 @0x1000, half 0x3456 @0x1004, word 0x789abcde @0x1008 → HTRANS NONSEQ on 3 consecutive cycles; 3 rsp pulses, rsp_error=0.
- Read with 2 wait states: read @0x2000, HREADY low 2 cycles, HRDATA=0xdeadbeef → rsp_rdata=0xdeadbeef 4 cycles after accept; next HADDR held stable during waits.
- Error response: write @0x3000 gets ERROR while read @0x3004 is pending → HTRANS=IDLE cycle, rsp_error=1, then 0x3004 re-issued NONSEQ.
- Clamp: cmd_size=3'b011 with MAX_SIZE=3'b010 → HSIZE=3'b010.
- Reset mid-wait: assert HRESET while HREADY low with A and D valid → outputs at reset values immediately; no rsp_valid after release.
- LANE_REPLICATE_EN: byte write 0xA5 @0x1001 → HWDATA=0xA5A5A5A5 (undefined: 0x000000A5).
